// File: rtl/sprite_compositor.sv
// Overlays one SPR_W x SPR_H sprite on the background pixel stream, feeding the VGA colour input.
// Three-stage pipeline on I_pix_ce: address generation, ROM wait, merge against the transparency key.
module sprite_compositor #(
  parameter int          SPR_W    = 16,
  parameter int          SPR_H    = 16,
  parameter int          ADDR_W   = 8,
  parameter logic [11:0] KEY      = 12'hF0F,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_pix_ce,
  input  logic [9:0]        I_col,
  input  logic [8:0]        I_row,
  input  logic              I_frame_start,
  input  logic              I_spr_en,
  input  logic [9:0]        I_spr_x,
  input  logic [8:0]        I_spr_y,
  input  logic              I_spr_flip,
  output logic [ADDR_W-1:0] O_spr_addr,
  input  logic [11:0]       I_spr_data,
  input  logic [11:0]       I_bg_data,
  output logic [11:0]       O_pix,
  output logic              O_hit,
  output logic              O_pos_latched
);

  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic        r_en;
  logic        r_flip;
  logic        r_act0, r_in0;
  logic        r_act1, r_in1;

  logic [10:0] w_c, w_r, w_x, w_y;
  logic [10:0] w_dx, w_dy, w_dx_sel;
  logic [21:0] w_lin;
  logic        w_active, w_inside;

  // All geometry is compared at 11 bits so x+SPR_W-1 cannot wrap; edge sprites simply clip.
  assign w_c = {1'b0, I_col};
  assign w_r = {2'b0, I_row};
  assign w_x = {1'b0, r_x};
  assign w_y = {2'b0, r_y};

  assign w_active = (w_c < 11'(H_ACTIVE)) && (w_r < 11'(V_ACTIVE));
  assign w_inside = r_en
                 && (w_c >= w_x) && (w_c <= w_x + 11'(SPR_W - 1))
                 && (w_r >= w_y) && (w_r <= w_y + 11'(SPR_H - 1));

  assign w_dx     = w_c - w_x;
  assign w_dy     = w_r - w_y;
  assign w_dx_sel = r_flip ? 11'(SPR_W - 1) - w_dx : w_dx;
  assign w_lin    = 22'(w_dy) * 22'(SPR_W) + 22'(w_dx_sel);

  // Shadow position: the stage-0 logic above reads the old values during the latch tick.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_en          <= 1'b0;
      r_flip        <= 1'b0;
      O_pos_latched <= 1'b0;
    end else begin
      O_pos_latched <= I_pix_ce && I_frame_start;
      if (I_pix_ce && I_frame_start) begin
        r_x    <= I_spr_x;
        r_y    <= I_spr_y;
        r_en   <= I_spr_en;
        r_flip <= I_spr_flip;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_spr_addr <= '0;
      r_act0     <= 1'b0;
      r_in0      <= 1'b0;
      r_act1     <= 1'b0;
      r_in1      <= 1'b0;
      O_pix      <= '0;
      O_hit      <= 1'b0;
    end else if (I_pix_ce) begin
      O_spr_addr <= w_inside ? w_lin[ADDR_W-1:0] : '0;
      r_act0     <= w_active;
      r_in0      <= w_inside;
      r_act1     <= r_act0;
      r_in1      <= r_in0;
      if (!r_act1) begin
        O_pix <= '0;
        O_hit <= 1'b0;
      end else if (r_in1 && (I_spr_data != KEY)) begin
        O_pix <= I_spr_data;
        O_hit <= 1'b1;
      end else begin
        O_pix <= I_bg_data;
        O_hit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a reference model pushes expected pixels into a
// scoreboard queue at sampling time; they are popped when the DUT's 2-tick pipeline delivers them.
module tb_sprite_compositor;

  localparam logic [11:0] KEY = 12'hF0F;

  typedef struct {
    logic [11:0] pix;
    logic        hit;
  } exp_t;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_pix_ce = 1'b0;
  logic [9:0]  I_col = '0;
  logic [8:0]  I_row = '0;
  logic        I_frame_start = 1'b0;
  logic        I_spr_en = 1'b0;
  logic [9:0]  I_spr_x = '0;
  logic [8:0]  I_spr_y = '0;
  logic        I_spr_flip = 1'b0;
  logic [7:0]  O_spr_addr;
  logic [11:0] I_spr_data;
  logic [11:0] I_bg_data = '0;
  logic [11:0] O_pix;
  logic        O_hit;
  logic        O_pos_latched;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t cur;

  // Reference model state
  int          m_x = 0, m_y = 0;
  bit          m_en = 0, m_flip = 0;
  bit          rom_key = 0;
  logic [11:0] bg_cur = '0, b1 = '0, b2 = '0;
  logic [11:0] rom_q = '0;

  sprite_compositor dut (
    .I_clk         (I_clk),
    .I_rst_n       (I_rst_n),
    .I_pix_ce      (I_pix_ce),
    .I_col         (I_col),
    .I_row         (I_row),
    .I_frame_start (I_frame_start),
    .I_spr_en      (I_spr_en),
    .I_spr_x       (I_spr_x),
    .I_spr_y       (I_spr_y),
    .I_spr_flip    (I_spr_flip),
    .O_spr_addr    (O_spr_addr),
    .I_spr_data    (I_spr_data),
    .I_bg_data     (I_bg_data),
    .O_pix         (O_pix),
    .O_hit         (O_hit),
    .O_pos_latched (O_pos_latched)
  );

  always #5 I_clk = ~I_clk;

  // Synchronous sprite ROM: data = address, or the key colour everywhere when rom_key is set.
  always @(posedge I_clk) if (I_pix_ce) rom_q <= rom_key ? KEY : {4'h0, O_spr_addr};
  assign I_spr_data = rom_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prime();
    sb.delete();
    cur = '{pix: 12'h000, hit: 1'b0};
    sb.push_back(cur);
    sb.push_back(cur);
  endtask

  // One pixel tick (ce high for one clk) followed by one idle clk.
  task automatic tick(input int c, input int r, input bit fs, input string tag);
    bit          act, ins;
    int          dx, addr;
    logic [11:0] rd;
    exp_t        e;
    act  = (c < 640) && (r < 480);
    ins  = m_en && (c >= m_x) && (c <= m_x + 15) && (r >= m_y) && (r <= m_y + 15);
    dx   = m_flip ? 15 - (c - m_x) : c - m_x;
    addr = ins ? (r - m_y) * 16 + dx : 0;
    rd   = rom_key ? KEY : 12'(addr);
    if (!act)                 e = '{pix: 12'h000, hit: 1'b0};
    else if (ins && rd != KEY) e = '{pix: rd, hit: 1'b1};
    else                      e = '{pix: bg_cur, hit: 1'b0};
    sb.push_back(e);

    I_col         = 10'(c);
    I_row         = 9'(r);
    I_frame_start = fs;
    I_bg_data     = b2;
    I_pix_ce      = 1'b1;
    @(posedge I_clk); #1;
    check({tag, " addr"}, 32'(O_spr_addr), 32'(addr));
    cur = sb.pop_front();
    check({tag, " pix"}, 32'(O_pix), 32'(cur.pix));
    check({tag, " hit"}, 32'(O_hit), 32'(cur.hit));
    check({tag, " pos_latched"}, 32'(O_pos_latched), 32'(fs));
    if (fs) begin
      m_x = int'(I_spr_x); m_y = int'(I_spr_y); m_en = I_spr_en; m_flip = I_spr_flip;
    end
    b2 = b1;
    b1 = bg_cur;
    I_pix_ce      = 1'b0;
    I_frame_start = 1'b0;
    @(posedge I_clk); #1;
    check({tag, " hold pix"}, 32'(O_pix), 32'(cur.pix));
    if (fs) check({tag, " pos pulse end"}, 32'(O_pos_latched), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge I_clk);
    #1;
    check("reset addr", 32'(O_spr_addr), 32'd0);
    check("reset pix", 32'(O_pix), 32'd0);
    check("reset hit", 32'(O_hit), 32'd0);
    check("reset pos", 32'(O_pos_latched), 32'd0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    prime();

    // Basic placement at (100,50), ROM data = address, background 00A
    bg_cur = 12'h00A;
    I_spr_en = 1'b1; I_spr_x = 10'd100; I_spr_y = 9'd50; I_spr_flip = 1'b0;
    tick(700, 490, 1, "latch1");
    tick(100, 50, 0, "tl");
    tick(101, 50, 0, "tl+1");
    tick(115, 65, 0, "br");
    tick(116, 50, 0, "right of");
    tick(99, 50, 0, "left of");
    tick(100, 66, 0, "below");
    tick(107, 60, 0, "mid");

    // Transparent key inside the sprite shows background
    tick(700, 0, 0, "flush0");
    rom_key = 1'b1;
    bg_cur  = 12'h123;
    tick(105, 55, 0, "key");
    tick(700, 0, 0, "flush1");
    rom_key = 1'b0;

    // Horizontal flip
    I_spr_flip = 1'b1;
    tick(700, 490, 1, "latch flip");
    tick(100, 50, 0, "flip tl");
    tick(115, 50, 0, "flip tr");
    tick(107, 60, 0, "flip mid");

    // Position change mid-frame is ignored until the next frame start
    I_spr_x = 10'd200; I_spr_flip = 1'b0;
    tick(100, 50, 0, "old pos");
    tick(200, 50, 0, "new pos early");
    tick(700, 490, 1, "latch move");
    tick(200, 50, 0, "new pos");
    tick(100, 50, 0, "old pos gone");
    tick(201, 50, 0, "pre reset");

    // Asynchronous reset mid-line
    #2;
    I_rst_n = 1'b0;
    #1;
    check("midreset addr", 32'(O_spr_addr), 32'd0);
    check("midreset pix", 32'(O_pix), 32'd0);
    check("midreset hit", 32'(O_hit), 32'd0);
    m_x = 0; m_y = 0; m_en = 0; m_flip = 0;
    b1 = '0; b2 = '0;
    @(negedge I_clk);
    I_rst_n = 1'b1;
    prime();
    bg_cur = 12'h456;
    tick(200, 50, 0, "post reset 0");
    tick(201, 50, 0, "post reset 1");
    tick(202, 50, 0, "post reset 2");

    // Right-edge clipping at x=630
    bg_cur = 12'h00A;
    I_spr_en = 1'b1; I_spr_x = 10'd630; I_spr_y = 9'd100;
    tick(700, 490, 1, "latch edge");
    tick(639, 105, 0, "edge last col");
    tick(640, 105, 0, "edge blank");
    tick(630, 100, 0, "edge first");
    tick(0, 0, 0, "edge drain");

    // Sprite fully off-screen never hits
    I_spr_x = 10'd700;
    tick(700, 490, 1, "latch off");
    tick(639, 100, 0, "off 639");
    tick(0, 100, 0, "off 0");
    tick(1, 100, 0, "off drain0");
    tick(2, 100, 0, "off drain1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
